// File: rtl/debounce_pkg.sv
// Shared types, defaults and width helpers for the debounce scan controller.
package debounce_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  localparam int DEF_N_CH       = 4;
  localparam int DEF_TICK_DIV   = 500000;
  localparam int DEF_STABLE_CNT = 3;

  function automatic int cnt_width(input int stable_cnt);
    return $clog2(stable_cnt + 1);
  endfunction

  function automatic int idx_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_STABLE_CNT);
  localparam int IDX_W = idx_width(DEF_N_CH);

endpackage

// File: rtl/debounce_scan_ctrl_if.sv
// Switch/debounce signal bundle. Sticky signals exist only when DB_STICKY_EN is defined.
interface debounce_scan_ctrl_if
  import debounce_pkg::*;
#(
  parameter int N_CH = DEF_N_CH
);

  logic [N_CH-1:0] sw;
  logic [N_CH-1:0] db;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic            tick;
`ifdef DB_STICKY_EN
  logic [N_CH-1:0] sticky_clr;
  logic [N_CH-1:0] sticky;

  modport master (output sw, sticky_clr, input db, rise, fall, tick, sticky);
  modport slave  (input sw, sticky_clr, output db, rise, fall, tick, sticky);
`else
  modport master (output sw, input db, rise, fall, tick);
  modport slave  (input sw, output db, rise, fall, tick);
`endif

endinterface

// File: rtl/debounce_scan_ctrl_prescaler.sv
// Sample-tick prescaler: counts 0..TICK_DIV-1 and strobes tick on the last count.
module db_prescaler
  import debounce_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] count;

  // NOTE: registers are written with <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset)              count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + PW'(1);
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Time-shared switch debouncer: one update datapath scanned round-robin per sample tick.
// Optional sticky rise flags are built when DB_STICKY_EN is defined.
module debounce_scan_ctrl
  import debounce_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int STABLE_CNT = DEF_STABLE_CNT
) (
  input logic                 clk,
  input logic                 reset,
  debounce_scan_ctrl_if.slave bus
);

  localparam int CNT_BITS = cnt_width(STABLE_CNT);
  localparam int IDX_BITS = idx_width(N_CH);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(STABLE_CNT - 1);
  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(N_CH - 1);

  generate
    if (TICK_DIV <= N_CH + 1) begin : g_bad_tick_div
      $error("debounce_scan_ctrl: TICK_DIV must exceed N_CH+1");
    end
    if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
      $error("debounce_scan_ctrl: N_CH must be in 1..32");
    end
    if (STABLE_CNT < 1 || STABLE_CNT > 15) begin : g_bad_stable
      $error("debounce_scan_ctrl: STABLE_CNT must be in 1..15");
    end
  endgenerate

  logic                tick;
  logic [N_CH-1:0]     sw_meta;
  logic [N_CH-1:0]     sw_s;
  logic [N_CH-1:0]     db_q;
  logic [N_CH-1:0]     rise_q;
  logic [N_CH-1:0]     fall_q;
  logic [CNT_BITS-1:0] cnt [N_CH];

  scan_state_t         state, state_nxt;
  logic [IDX_BITS-1:0] ch_idx, ch_idx_nxt;

  logic                svc;
  logic                mismatch;
  logic                flip;
  logic [CNT_BITS-1:0] cnt_nxt;

  db_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= '0;
      sw_s    <= '0;
    end else begin
      sw_meta <= bus.sw;
      sw_s    <= sw_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ch_idx <= '0;
    end else begin
      state  <= state_nxt;
      ch_idx <= ch_idx_nxt;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    ch_idx_nxt = ch_idx;
    unique case (state)
      IDLE: begin
        if (tick) begin
          state_nxt  = SCAN;
          ch_idx_nxt = '0;
        end
      end
      SCAN: begin
        if (ch_idx == IDX_LAST) state_nxt = IDLE;
        else                    ch_idx_nxt = ch_idx + IDX_BITS'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared update for the channel currently selected by the scan.
  always_comb begin
    svc      = (state == SCAN);
    mismatch = sw_s[ch_idx] ^ db_q[ch_idx];
    flip     = svc && mismatch && (cnt[ch_idx] == CNT_LAST);
    cnt_nxt  = '0;
    if (mismatch && !flip) cnt_nxt = cnt[ch_idx] + CNT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      // NOTE: the count array is a handful of flops, not a RAM, so it is cleared with the rest of the state.
      for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
    end else begin
      rise_q <= '0;
      fall_q <= '0;
      if (svc) begin
        cnt[ch_idx] <= cnt_nxt;
        if (flip) begin
          db_q[ch_idx]   <= ~db_q[ch_idx];
          rise_q[ch_idx] <= ~db_q[ch_idx];
          fall_q[ch_idx] <= db_q[ch_idx];
        end
      end
    end
  end

  assign bus.db   = db_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
  assign bus.tick = tick;

`ifdef DB_STICKY_EN
  logic [N_CH-1:0] sticky_q;

  // Set has priority over a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) sticky_q <= '0;
    else       sticky_q <= (sticky_q & ~bus.sticky_clr) | rise_q;
  end

  assign bus.sticky = sticky_q;
`endif

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed bench for debounce_scan_ctrl with N_CH=4, TICK_DIV=8, STABLE_CNT=3.
module tb_debounce_scan_ctrl;
  import debounce_pkg::*;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   rise_cnt [4];
  int   fall_cnt [4];

  debounce_scan_ctrl_if #(.N_CH(4)) bus ();

  debounce_scan_ctrl #(.N_CH(4), .TICK_DIV(8), .STABLE_CNT(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_events();
    for (int k = 0; k < 4; k++) begin
      rise_cnt[k] = 0;
      fall_cnt[k] = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (bus.rise[k]) rise_cnt[k]++;
      if (bus.fall[k]) fall_cnt[k]++;
    end
  endtask

  // Advances to the negedge where tick is high; n is the number of cycles taken.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.tick && n < 40);
    checks++;
    if (bus.tick !== 1'b1) begin
      errors++;
      $display("FAIL tick_timeout: tick=%b after %0d cycles, required 1", bus.tick, n);
    end
  endtask

  // One full tick period: ends 6 cycles after the tick, with the scan finished.
  task automatic run_tick();
    int n;
    wait_tick(n);
    repeat (6) step();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    clear_events();
  endtask

  task automatic test_reset();
    int n;
    bus.sw = '0;
    reset  = 1'b1;
    repeat (3) step();
    checks++; if (bus.db !== 4'b0000)   begin errors++; $display("FAIL rst_db: got %b want 0000", bus.db); end
    checks++; if (bus.rise !== 4'b0000) begin errors++; $display("FAIL rst_rise: got %b want 0000", bus.rise); end
    checks++; if (bus.fall !== 4'b0000) begin errors++; $display("FAIL rst_fall: got %b want 0000", bus.fall); end
    checks++; if (bus.tick !== 1'b0)    begin errors++; $display("FAIL rst_tick: got %b want 0", bus.tick); end
    reset = 1'b0;
    clear_events();
    wait_tick(n);
    checks++; if (n != 7) begin errors++; $display("FAIL first_tick: after %0d negedges, want 7 (cycle 8)", n); end
    wait_tick(n);
    checks++; if (n != 8) begin errors++; $display("FAIL tick_period: %0d cycles, want 8", n); end
    repeat (6) step();
    checks++; if (bus.db !== 4'b0000) begin errors++; $display("FAIL idle_db: got %b want 0000", bus.db); end
    checks++;
    if (rise_cnt.sum() != 0 || fall_cnt.sum() != 0) begin
      errors++; $display("FAIL idle_events: rises=%0d falls=%0d want 0", rise_cnt.sum(), fall_cnt.sum());
    end
  endtask

  task automatic test_rise();
    int n;
    clear_events();
    bus.sw[0] = 1'b1;
    run_tick();
    run_tick();
    checks++; if (bus.db !== 4'b0000) begin errors++; $display("FAIL rise_early: got %b want 0000", bus.db); end
    wait_tick(n);
    step();
    checks++; if (bus.db !== 4'b0000)   begin errors++; $display("FAIL rise_t1_db: got %b want 0000", bus.db); end
    checks++; if (bus.rise !== 4'b0000) begin errors++; $display("FAIL rise_t1_rise: got %b want 0000", bus.rise); end
    step();
    checks++; if (bus.db !== 4'b0001)   begin errors++; $display("FAIL rise_t2_db: got %b want 0001", bus.db); end
    checks++; if (bus.rise !== 4'b0001) begin errors++; $display("FAIL rise_t2_rise: got %b want 0001", bus.rise); end
    step();
    checks++; if (bus.rise !== 4'b0000) begin errors++; $display("FAIL rise_t3_rise: got %b want 0000", bus.rise); end
    repeat (3) step();
    checks++; if (rise_cnt[0] != 1)     begin errors++; $display("FAIL rise_pulse_len: got %0d want 1", rise_cnt[0]); end
    checks++; if (fall_cnt.sum() != 0)  begin errors++; $display("FAIL rise_no_fall: got %0d want 0", fall_cnt.sum()); end
  endtask

  task automatic test_glitch();
    clear_events();
    bus.sw[2] = 1'b1;
    run_tick();
    run_tick();
    bus.sw[2] = 1'b0;
    run_tick();
    bus.sw[2] = 1'b1;
    run_tick();
    run_tick();
    bus.sw[2] = 1'b0;
    run_tick();
    run_tick();
    checks++; if (bus.db !== 4'b0001) begin errors++; $display("FAIL glitch_db: got %b want 0001", bus.db); end
    checks++; if (rise_cnt[2] != 0)   begin errors++; $display("FAIL glitch_rise: got %0d want 0", rise_cnt[2]); end
  endtask

  task automatic test_fall();
    clear_events();
    bus.sw[1] = 1'b1;
    repeat (3) run_tick();
    checks++; if (bus.db !== 4'b0011) begin errors++; $display("FAIL fall_setup: got %b want 0011", bus.db); end
    clear_events();
    bus.sw[1] = 1'b0;
    repeat (2) run_tick();
    checks++; if (bus.db !== 4'b0011) begin errors++; $display("FAIL fall_early: got %b want 0011", bus.db); end
    run_tick();
    checks++; if (bus.db !== 4'b0001)  begin errors++; $display("FAIL fall_db: got %b want 0001", bus.db); end
    checks++; if (fall_cnt[1] != 1)    begin errors++; $display("FAIL fall_pulse: got %0d want 1", fall_cnt[1]); end
    checks++; if (rise_cnt.sum() != 0) begin errors++; $display("FAIL fall_no_rise: got %0d want 0", rise_cnt.sum()); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [3:0] exp_db, exp_rise;
    bus.sw = 4'b1111;
    apply_reset();
    repeat (2) run_tick();
    checks++; if (bus.db !== 4'b0000) begin errors++; $display("FAIL b2b_early: got %b want 0000", bus.db); end
    wait_tick(n);
    for (int c = 1; c <= 5; c++) begin
      step();
      exp_db   = 4'b0000;
      exp_rise = 4'b0000;
      for (int k = 0; k < 4; k++) begin
        if (k + 2 <= c) exp_db[k] = 1'b1;
        if (k + 2 == c) exp_rise[k] = 1'b1;
      end
      checks++; if (bus.db !== exp_db)     begin errors++; $display("FAIL b2b_db[c%0d]: got %b want %b", c, bus.db, exp_db); end
      checks++; if (bus.rise !== exp_rise) begin errors++; $display("FAIL b2b_rise[c%0d]: got %b want %b", c, bus.rise, exp_rise); end
    end
    step();
  endtask

  task automatic test_reset_mid_scan();
    int n;
    bus.sw = 4'b1111;
    apply_reset();
    repeat (2) run_tick();
    wait_tick(n);
    repeat (3) step();
    checks++; if (bus.db !== 4'b0011) begin errors++; $display("FAIL mid_pre_db: got %b want 0011", bus.db); end
    reset = 1'b1;
    step();
    checks++; if (bus.db !== 4'b0000)   begin errors++; $display("FAIL mid_db: got %b want 0000", bus.db); end
    checks++; if (bus.rise !== 4'b0000) begin errors++; $display("FAIL mid_rise: got %b want 0000", bus.rise); end
    checks++; if (bus.fall !== 4'b0000) begin errors++; $display("FAIL mid_fall: got %b want 0000", bus.fall); end
    checks++; if (bus.tick !== 1'b0)    begin errors++; $display("FAIL mid_tick: got %b want 0", bus.tick); end
    checks++; if (dut.state !== IDLE)   begin errors++; $display("FAIL mid_state: got %0d want IDLE", dut.state); end
    reset = 1'b0;
    clear_events();
    wait_tick(n);
    checks++; if (n != 7) begin errors++; $display("FAIL mid_next_tick: after %0d negedges, want 7 (cycle 8)", n); end
    repeat (6) step();
    run_tick();
    checks++; if (bus.db !== 4'b0000) begin errors++; $display("FAIL mid_cnt_cleared: got %b want 0000", bus.db); end
    run_tick();
    checks++; if (bus.db !== 4'b1111) begin errors++; $display("FAIL mid_recover: got %b want 1111", bus.db); end
  endtask

`ifdef DB_STICKY_EN
  task automatic test_sticky();
    int n;
    bus.sw = 4'b0001;
    bus.sticky_clr = '0;
    apply_reset();
    checks++; if (bus.sticky !== 4'b0000) begin errors++; $display("FAIL sticky_rst: got %b want 0000", bus.sticky); end
    repeat (2) run_tick();
    wait_tick(n);
    step();
    bus.sticky_clr = 4'b0001;
    step();
    checks++; if (bus.rise !== 4'b0001)   begin errors++; $display("FAIL sticky_rise: got %b want 0001", bus.rise); end
    checks++; if (bus.sticky !== 4'b0000) begin errors++; $display("FAIL sticky_pre: got %b want 0000", bus.sticky); end
    step();
    checks++; if (bus.sticky !== 4'b0001) begin errors++; $display("FAIL sticky_set_wins: got %b want 0001", bus.sticky); end
    step();
    checks++; if (bus.sticky !== 4'b0000) begin errors++; $display("FAIL sticky_clear: got %b want 0000", bus.sticky); end
    bus.sticky_clr = '0;
  endtask
`endif

  initial begin
    reset  = 1'b1;
    bus.sw = '0;
`ifdef DB_STICKY_EN
    bus.sticky_clr = '0;
`endif
    clear_events();
    test_reset();
    test_rise();
    test_glitch();
    test_fall();
    test_back_to_back();
    test_reset_mid_scan();
`ifdef DB_STICKY_EN
    test_sticky();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_scan_ctrl.md
Name: debounce_scan_ctrl

Overview:
Scheduler that shares one debounce-update datapath across N_CH switch inputs. An internal prescaler issues a sample tick. Each tick starts a round-robin scan that updates one channel's debounce state per clock. Produces the debounced level vector plus one-cycle rise/fall events for the button/switch front end.

Parameters:
N_CH, 4, number of switch channels; legal range 1..32.
TICK_DIV, 500000, clk cycles per sample tick; must be > N_CH+1 (elaboration-time assertion).
STABLE_CNT, 3, consecutive mismatching samples needed to flip db; legal range 1..15.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sw  in  N_CH  raw asynchronous switch inputs
db  out  N_CH  debounced level per channel
rise  out  N_CH  one-cycle pulse when db[k] goes 0->1
fall  out  N_CH  one-cycle pulse when db[k] goes 1->0
tick  out  1  one-cycle sample strobe (observability)
sticky_clr  in  N_CH  per-channel clear for sticky flags (DB_STICKY_EN only)
sticky  out  N_CH  latched rise events (DB_STICKY_EN only)

Behaviour:
- One clock. Reset is synchronous and active-high: the clock port is clk and the reset port is reset.
- Reset values: db=0, rise=0, fall=0, tick=0, sticky=0, prescaler=0, all per-channel counts=0, sync flops=0, FSM=IDLE. Reset mid-scan aborts the scan. No partial channel update is kept.
- Synchroniser: 2-FF per channel on sw, giving sw_s. There is 2 cycles of input latency before the value is visible to the scheduler.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle the count equals TICK_DIV-1. The first tick is in the TICK_DIV-th cycle after reset deasserts.
- Scan FSM, two states:
  - IDLE: on tick, go to SCAN with ch_idx=0.
  - SCAN: service channel ch_idx. If ch_idx==N_CH-1, go to IDLE. Otherwise ch_idx+1.
  - Channel k is serviced in cycle tick+1+k.
  - A tick cannot occur during SCAN, guaranteed by the TICK_DIV constraint.
- Channel update, shared datapath, one channel per cycle:
  - If sw_s[k]==db[k]: cnt[k] <= 0.
  - Else if cnt[k]==STABLE_CNT-1: db[k] <= ~db[k], cnt[k] <= 0, and rise[k] or fall[k] is asserted the following cycle for exactly 1 cycle.
  - Else: cnt[k] <= cnt[k]+1.
- cnt width: $clog2(STABLE_CNT+1). cnt never exceeds STABLE_CNT-1, so no wrap is possible.
- Glitch shorter than one tick period: either unsampled, or it resets the count on the next matching sample. db is unaffected.
- Worst-case latency from a stable sw change to db: 2 + STABLE_CNT*TICK_DIV + N_CH cycles.
- Unserviced channels hold db and cnt. rise and fall are 0 outside event cycles.
- Rise and fall are mutually exclusive per channel, since a channel flips at most once per scan.

Optional Feature:
Macro DB_STICKY_EN.
- Defined: sticky[k] sets when rise[k] pulses and clears when sticky_clr[k]=1. A simultaneous set and clear leaves sticky[k]=1 (set wins). Reset clears it.
- Undefined: the sticky_clr and sticky ports and their logic are absent.

Decomposition:
- Package debounce_pkg:
  - scan_state_t enum {IDLE, SCAN}
  - width helper localparams (CNT_W, IDX_W)
  - default constants for N_CH, TICK_DIV and STABLE_CNT
- One sub-module: db_prescaler (TICK_DIV counter producing tick).
- Synchroniser, FSM and channel datapath stay in the top.

Test Plan:
All scenarios use N_CH=4, TICK_DIV=8, STABLE_CNT=3.
1. Reset held 3 cycles then released, sw=0 -> db=0, rise=0, fall=0 throughout; tick first high in cycle 8 after release, then every 8 cycles.
2. sw[0]=1 held -> db[0]=1 after the 3rd tick's scan; rise[0] high exactly 1 cycle; db[3:1]=0; fall=0.
3. sw[2]=1 for 2 tick periods then 0 -> db[2] stays 0, no rise[2]; cnt[2] returns to 0.
4. With db[1]=1, sw[1]=0 held 3 tick periods -> db[1]=0 and fall[1] pulses once; no rise.
5. sw=4'b1111 simultaneously -> db bits flip in consecutive cycles tick+1..tick+4 of the 3rd scan; rise pulses staggered the same way.
6. Reset asserted during SCAN at ch_idx=2 -> next cycle all outputs 0, FSM=IDLE; next tick 8 cycles after release.
   With DB_STICKY_EN: rise[0] while sticky_clr[0]=1 -> sticky[0]=1; sticky_clr[0] alone next cycle -> sticky[0]=0.
